adaptor2x2_instruction_fetch: RTL and testbench
===============================================

// Module: adaptor2x2_instruction_fetch
// PURPOSE
//  Fetch stage that sits directly downstream of the 1024x32 single-port instruction memory (Avalon s1).
//  - Drives word addresses to the memory and captures readdata one cycle later.
//  - Buffers {pc, instr} pairs in a small FIFO and presents them to the core over valid/ready.
//  - Supports a redirect (branch/jump) that flushes buffered and in-flight words.
// PARAMETERS
//  ADDR_W      10  memory word-address width; PC wraps modulo 2**ADDR_W
//  DATA_W      32  instruction width; equals memory readdata width
//  FIFO_DEPTH  4   instruction buffer entries; power of 2, >=2
//  RESET_PC    0   word address fetched first after reset
// PORTS
//  clk              in   1       single clock; memory shares it
//  reset_n          in   1       asynchronous, active-low reset
//  fetch_enable     in   1       1 = issue new reads; 0 = stall issue, drain FIFO normally
//  redirect_valid   in   1       1-cycle pulse: flush and restart at redirect_pc
//  redirect_pc      in   ADDR_W  new fetch word address
//  imem_address     out  ADDR_W  memory word address (= current pc)
//  imem_chipselect  out  1       high on issue cycles
//  imem_clken       out  1       memory clock enable; constant 1 out of reset
//  imem_write       out  1       tied 0 (read-only master)
//  imem_byteenable  out  4       tied 4'b1111
//  imem_writedata   out  DATA_W  tied 0
//  imem_readdata    in   DATA_W  memory output; valid 1 cycle after address is presented
//  instr_valid      out  1       FIFO head valid
//  instr_ready      in   1       consumer accepts head when valid & ready
//  instr_data       out  DATA_W  FIFO head instruction
//  instr_pc         out  ADDR_W  FIFO head word address
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - pc=RESET_PC, FIFO empty, pending=0.
//   - instr_valid=0, imem_chipselect=0, imem_address=RESET_PC, instr_data/instr_pc=0, imem_clken=1.
//  Issue rule, cycle N:
//   - issue = fetch_enable & ~redirect_valid & (count + pending - pop < FIFO_DEPTH).
//   - pop = instr_valid & instr_ready.
//   - On issue: chipselect=1; pending<=1; pending_pc<=pc; pc<=pc+1 (wraps 2**ADDR_W-1 -> 0).
//  Capture, cycle N+1:
//   - If pending & ~kill, push {pending_pc, imem_readdata}.
//   - Fixed read latency 1; no wait states.
//  Throughput and ordering:
//   - Sustained 1 instr/cycle when ready is held high.
//   - First instr_valid appears 2 cycles after issue (1 RAM + 1 FIFO register).
//   - FIFO never overflows: the credit rule reserves a slot for every in-flight read.
//   - Push and pop in the same cycle are allowed at any occupancy, including full.
//  Redirect in cycle R (highest priority):
//   - A pop in cycle R still completes; the consumer owns that word.
//   - FIFO cleared at the end of R; pc<=redirect_pc; no issue in R.
//   - A read issued in R-1 is marked kill and its response in R is not pushed.
//   - First issue at redirect_pc in R+1; instr_valid earliest in R+3.
//   - Back-to-back redirects: the last one wins.
//  fetch_enable=0: no new issue; an in-flight read still completes and pushes; the FIFO drains.
//  instr_data/instr_pc stay stable while instr_valid & ~instr_ready.
//  Reset asserted mid-operation: all state clears immediately and in-flight data is discarded.
// STRUCTURE
//  Package adaptor2x2_fetch_pkg holds:
//   - IMEM_ADDR_W=10, IMEM_DATA_W=32
//   - typedef fetch_entry_t {pc, instr}
//  Sub-module adaptor2x2_fetch_fifo:
//   - synchronous FIFO of fetch_entry_t, registered head, count output, synchronous flush input.
//  Top level holds the pc register, pending/kill flags and credit logic; no other hierarchy.
// TESTING
//  Bench uses a behavioural 1-cycle-latency RAM model with mem[i]=32'hA000_0000+i.
//  1 Streaming: reset, enable=1, ready=1 -> instr_pc 0,1,2,... with data A0000000+pc, one per cycle from cycle 2.
//  2 Backpressure: ready=0 for 10 cycles -> exactly 4 accepted-pending entries, chipselect drops, no loss/dup; after ready=1, pc sequence is contiguous.
//  3 Redirect: at pc=5 in flight, pulse redirect_pc=0x200 -> words 5/6 never appear; next valid is pc 0x200 three cycles later.
//  4 Wrap: redirect to 0x3FE -> pcs 0x3FE, 0x3FF, 0x000, 0x001 in order.
//  5 Redirect with pop: redirect while valid&ready -> that head counts as consumed and the FIFO then starts empty.
//  6 Async reset: assert reset_n=0 mid-stream between clock edges -> instr_valid=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/adaptor2x2_fetch_pkg.sv
// Shared widths and the {pc, instr} record carried through the fetch buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adaptor2x2_fetch_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_BE_W   = IMEM_DATA_W / 8;

    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] pc;
        logic [IMEM_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Word-address increment; the PC space wraps modulo 2**IMEM_ADDR_W.
    function automatic logic [IMEM_ADDR_W-1:0] pc_next(input logic [IMEM_ADDR_W-1:0] pc);
        return pc + IMEM_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/adaptor2x2_instruction_fetch_if.sv
// Instruction-memory master bus plus the fetch-to-core valid/ready channel.
// Latency: n/a (wires only).
// Backpressure: instr_ready from the core; the memory side has no wait states.
// master: fetch stage (drives imem_* requests and instr_valid/data/pc).
// slave : memory + consumer (drives imem_readdata and instr_ready).
interface adaptor2x2_instruction_fetch_if;
    import adaptor2x2_fetch_pkg::*;

    logic [IMEM_ADDR_W-1:0] imem_address;
    logic                   imem_chipselect;
    logic                   imem_clken;
    logic                   imem_write;
    logic [IMEM_BE_W-1:0]   imem_byteenable;
    logic [IMEM_DATA_W-1:0] imem_writedata;
    logic [IMEM_DATA_W-1:0] imem_readdata;

    logic                   instr_valid;
    logic                   instr_ready;
    logic [IMEM_DATA_W-1:0] instr_data;
    logic [IMEM_ADDR_W-1:0] instr_pc;

    modport master (
        output imem_address, imem_chipselect, imem_clken, imem_write,
        output imem_byteenable, imem_writedata,
        input  imem_readdata,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_address, imem_chipselect, imem_clken, imem_write,
        input  imem_byteenable, imem_writedata,
        output imem_readdata,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/adaptor2x2_fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with a registered head and occupancy count.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none internally; the caller guarantees free space (push while full only with pop).
// Ports: clk, reset_n, flush (sync clear, wins over push/pop), push_vld/push_dat,
//        pop, head_vld/head_dat (zero when empty), count.
module adaptor2x2_fetch_fifo
    import adaptor2x2_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push_vld,
    input  fetch_entry_t     push_dat,
    input  logic             pop,
    output logic             head_vld,
    output fetch_entry_t     head_dat,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        do_pop  = pop & (cnt_q != '0);
        // When full, the slot being written is the one the head is leaving, so
        // a simultaneous push/pop is safe at any occupancy.
        do_push = push_vld & ((cnt_q != CNT_W'(DEPTH)) | do_pop);

        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_dat;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_vld = (cnt_q != '0);
    // Zero the head when empty so the consumer never sees stale entries after a flush.
    assign head_dat = head_vld ? mem_q[rd_q] : '0;
    assign count    = cnt_q;

endmodule

// File: rtl/adaptor2x2_instruction_fetch.sv
// Fetch stage: issues word reads to a 1-cycle SRAM and buffers {pc, instr} for the core.
// Latency: instr_valid two cycles after issue (one RAM cycle, one buffer register).
// Backpressure: credit rule stops issue when buffered + in-flight words fill the FIFO.
// Ports: clk, reset_n (async active-low), fetch_enable, redirect_valid/redirect_pc,
//        bus (master side: imem_* requests, imem_readdata, instr_valid/ready/data/pc).
module adaptor2x2_instruction_fetch
    import adaptor2x2_fetch_pkg::*;
#(
    parameter int                     FIFO_DEPTH = 4,
    parameter logic [IMEM_ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fetch_enable,
    input  logic                   redirect_valid,
    input  logic [IMEM_ADDR_W-1:0] redirect_pc,
    adaptor2x2_instruction_fetch_if.master bus
);

    localparam int ADDR_W = IMEM_ADDR_W;
    localparam int DATA_W = IMEM_DATA_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;
    logic              pending_q, pending_d;

    logic              pop;
    logic              kill;
    logic              issue;
    logic              push;
    logic              credit_ok;
    logic [CNT_W:0]    inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              head_vld;
    fetch_entry_t      head_dat;
    fetch_entry_t      push_dat;

    always_comb begin
        pop       = bus.instr_valid & bus.instr_ready;
        // The only read that can be in flight during a redirect was issued the
        // cycle before; its response arrives in the redirect cycle itself, so
        // the kill marker is simply the redirect pulse.
        kill      = redirect_valid;

        // Slots already claimed: buffered words plus the read whose data lands
        // this cycle, less the word leaving this cycle.
        inflight  = {1'b0, fifo_count} + (CNT_W+1)'(pending_q) - (CNT_W+1)'(pop);
        credit_ok = (inflight < (CNT_W+1)'(FIFO_DEPTH));

        // No memory traffic while reset is held.
        issue     = reset_n & fetch_enable & ~redirect_valid & credit_ok;
        push      = pending_q & ~kill;

        push_dat.pc    = pending_pc_q;
        push_dat.instr = bus.imem_readdata;

        pc_d         = pc_q;
        pending_d    = issue;
        pending_pc_d = pending_pc_q;

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d         = pc_next(pc_q);
            pending_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    adaptor2x2_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign bus.imem_address    = pc_q;
    assign bus.imem_chipselect = issue;
    assign bus.imem_clken      = 1'b1;
    assign bus.imem_write      = 1'b0;
    assign bus.imem_byteenable = '1;
    assign bus.imem_writedata  = '0;

    assign bus.instr_valid     = head_vld;
    assign bus.instr_data      = head_dat.instr;
    assign bus.instr_pc        = head_dat.pc;

endmodule

// File: tb/tb_adaptor2x2_instruction_fetch.sv
module tb_adaptor2x2_instruction_fetch;
    import adaptor2x2_fetch_pkg::*;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   fetch_enable;
    logic                   redirect_valid;
    logic [IMEM_ADDR_W-1:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    adaptor2x2_instruction_fetch_if bif ();

    adaptor2x2_instruction_fetch #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   ('0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_enable   (fetch_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bif)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: mem[i] = A000_0000 + i, one-cycle read latency.
    always @(posedge clk) begin
        if (bif.imem_chipselect)
            bif.imem_readdata <= 32'hA000_0000 + {22'b0, bif.imem_address};
    end

    function automatic logic [31:0] word_of(input logic [IMEM_ADDR_W-1:0] a);
        return 32'hA000_0000 + {22'b0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: the core must see one contiguous pc stream per
    // redirect epoch, each word matching memory, with no more than DEPTH words
    // ever claimed (buffered or in flight) and issue whenever room exists.
    logic [IMEM_ADDR_W-1:0] m_exp_pc, m_issue_pc;
    int                     m_claimed;
    logic                   prev_stall;
    logic [IMEM_ADDR_W-1:0] prev_pc;
    logic [31:0]            prev_data;

    always @(negedge clk) begin
        logic pop;
        logic exp_cs;
        if (!reset_n) begin
            m_exp_pc   = '0;
            m_issue_pc = '0;
            m_claimed  = 0;
            prev_stall = 1'b0;
        end else begin
            pop    = bif.instr_valid & bif.instr_ready;
            exp_cs = fetch_enable & ~redirect_valid & ((m_claimed - int'(pop)) < DEPTH);
            chk("m_chipselect", bif.imem_chipselect, exp_cs);
            chk("m_static", {bif.imem_write, bif.imem_byteenable, bif.imem_clken, bif.imem_writedata},
                {1'b0, 4'hF, 1'b1, 32'h0});
            if (prev_stall) begin
                chk("m_hold_valid", bif.instr_valid, 1'b1);
                chk("m_hold_pc", bif.instr_pc, prev_pc);
                chk("m_hold_data", bif.instr_data, prev_data);
            end
            if (pop) begin
                chk("m_pop_pc", bif.instr_pc, m_exp_pc);
                chk("m_pop_data", bif.instr_data, word_of(m_exp_pc));
                m_exp_pc  = m_exp_pc + 1'b1;
                m_claimed = m_claimed - 1;
            end
            if (bif.imem_chipselect) begin
                chk("m_issue_addr", bif.imem_address, m_issue_pc);
                m_issue_pc = m_issue_pc + 1'b1;
                m_claimed  = m_claimed + 1;
            end
            if (redirect_valid) begin
                m_exp_pc   = redirect_pc;
                m_issue_pc = redirect_pc;
                m_claimed  = 0;
            end
            chk("m_claim_bound", (m_claimed <= DEPTH), 1'b1);
            prev_stall = bif.instr_valid & ~bif.instr_ready & ~redirect_valid;
            prev_pc    = bif.instr_pc;
            prev_data  = bif.instr_data;
        end
    end

    // First ten cycles after reset release with enable and ready held high.
    task automatic startup_check(input string tag);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk({tag, "_cs0"}, bif.imem_chipselect, 1'b1);
                chk({tag, "_addr0"}, bif.imem_address, 10'h000);
            end
            chk({tag, "_valid"}, bif.instr_valid, (c >= 2));
            if (c >= 2) begin
                chk({tag, "_pc"}, bif.instr_pc, 10'(c - 2));
                chk({tag, "_data"}, bif.instr_data, 32'hA000_0000 + 32'(c - 2));
            end
        end
    endtask

    task automatic pulse_redirect(input logic [IMEM_ADDR_W-1:0] target);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  got;
        int  idx;
        logic found;
        logic [IMEM_ADDR_W-1:0] wrap_exp [4];
        wrap_exp[0] = 10'h3FE;
        wrap_exp[1] = 10'h3FF;
        wrap_exp[2] = 10'h000;
        wrap_exp[3] = 10'h001;

        reset_n          = 1'b0;
        fetch_enable     = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        bif.instr_ready  = 1'b1;

        // Reset state
        #12;
        chk("rst_valid", bif.instr_valid, 1'b0);
        chk("rst_cs", bif.imem_chipselect, 1'b0);
        chk("rst_addr", bif.imem_address, 10'h000);
        chk("rst_data", bif.instr_data, 32'h0);
        chk("rst_pc", bif.instr_pc, 10'h000);
        chk("rst_clken", bif.imem_clken, 1'b1);

        // 1 Streaming
        @(posedge clk); #1;
        reset_n = 1'b1;
        startup_check("stream");

        // 2 Backpressure: buffer saturates at DEPTH words, issue stops
        @(posedge clk); #1;
        bif.instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("bp_valid", bif.instr_valid, 1'b1);
        chk("bp_cs", bif.imem_chipselect, 1'b0);
        @(posedge clk); #1;
        fetch_enable    = 1'b0;
        bif.instr_ready = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bif.instr_valid && bif.instr_ready) n++;
        end
        chk("bp_buffered", n, 4);
        chk("bp_drained", bif.instr_valid, 1'b0);
        @(posedge clk); #1;
        fetch_enable = 1'b1;
        repeat (8) @(negedge clk);

        // 3 + 5 Redirect while pc 5 is in flight and the head is being popped
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bif.imem_chipselect && bif.imem_address == 10'h005) begin
                found = 1'b1;
                break;
            end
        end
        chk("rd_found5", found, 1'b1);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 10'h200;
        @(negedge clk);
        chk("rd_R_cs", bif.imem_chipselect, 1'b0);
        chk("rd_R_pop_valid", bif.instr_valid, 1'b1);
        chk("rd_R_pop_pc", bif.instr_pc, 10'h004);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd_R1_cs", bif.imem_chipselect, 1'b1);
        chk("rd_R1_addr", bif.imem_address, 10'h200);
        chk("rd_R1_empty", bif.instr_valid, 1'b0);
        @(negedge clk);
        chk("rd_R2_empty", bif.instr_valid, 1'b0);
        @(negedge clk);
        chk("rd_R3_valid", bif.instr_valid, 1'b1);
        chk("rd_R3_pc", bif.instr_pc, 10'h200);
        chk("rd_R3_data", bif.instr_data, 32'hA000_0200);
        repeat (4) @(negedge clk);

        // 4 Wrap across the top of the address space
        pulse_redirect(10'h3FE);
        got = 0;
        for (int i = 0; i < 20 && got < 4; i++) begin
            @(negedge clk);
            if (bif.instr_valid && bif.instr_ready) begin
                chk("wrap_pc", bif.instr_pc, wrap_exp[got]);
                got++;
            end
        end
        chk("wrap_count", got, 4);

        // Back-to-back redirects: the later target wins
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 10'h300;
        @(posedge clk); #1;
        redirect_pc    = 10'h310;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        idx = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bif.instr_valid) begin
                idx = i;
                break;
            end
        end
        chk("b2b_latency", idx, 2);
        chk("b2b_pc", bif.instr_pc, 10'h310);

        // Disable with a read in flight: it still lands, then the buffer drains
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bif.imem_chipselect) begin
                found = 1'b1;
                break;
            end
        end
        chk("dis_found_issue", found, 1'b1);
        @(posedge clk); #1;
        fetch_enable = 1'b0;
        repeat (8) @(negedge clk);
        chk("dis_drained", bif.instr_valid, 1'b0);
        @(posedge clk); #1;
        fetch_enable = 1'b1;
        repeat (8) @(negedge clk);

        // 6 Asynchronous reset between clock edges
        @(posedge clk); #2;
        chk("arst_pre_valid", bif.instr_valid, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_valid", bif.instr_valid, 1'b0);
        chk("arst_cs", bif.imem_chipselect, 1'b0);
        chk("arst_addr", bif.imem_address, 10'h000);
        chk("arst_pc", bif.instr_pc, 10'h000);
        chk("arst_data", bif.instr_data, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        startup_check("arst_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
